// File: rtl/ex_pipe_stage_pkg.sv
// ============================================================================
// Module      : ex_pipe_stage_pkg
// Description : Shared definitions for the Merlin execute stage: datapath
//               width default, destination zones, ALU op encodings, branch
//               compare funct3 codes and shadow FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_pipe_stage_pkg;

  // Core-wide default datapath width (32 or 64)
  localparam int C_XLEN_DEFAULT = 32;

  // Destination of an executed instruction
  typedef enum logic [1:0] {
    ZONE_NONE    = 2'd0,
    ZONE_REGFILE = 2'd1,
    ZONE_LOADQ   = 2'd2,
    ZONE_STOREQ  = 2'd3
  } t_zone;

  // ALU operation encodings
  typedef enum logic [3:0] {
    ALU_ADD        = 4'd0,
    ALU_SUB        = 4'd1,
    ALU_SLL        = 4'd2,
    ALU_SLT        = 4'd3,
    ALU_SLTU       = 4'd4,
    ALU_XOR        = 4'd5,
    ALU_SRL        = 4'd6,
    ALU_SRA        = 4'd7,
    ALU_OR         = 4'd8,
    ALU_AND        = 4'd9,
    ALU_PASS_RIGHT = 4'd10
  } t_alu_op;

  // Branch comparator funct3 encodings
  localparam logic [2:0] C_F3_BEQ  = 3'b000;
  localparam logic [2:0] C_F3_BNE  = 3'b001;
  localparam logic [2:0] C_F3_BLT  = 3'b100;
  localparam logic [2:0] C_F3_BGE  = 3'b101;
  localparam logic [2:0] C_F3_BLTU = 3'b110;
  localparam logic [2:0] C_F3_BGEU = 3'b111;

  // Branch-shadow state machine
  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_SHADOW = 1'b1
  } t_ex_state;

endpackage

`default_nettype wire

// File: rtl/ex_alu.sv
// ============================================================================
// Module      : ex_alu
// Description : Purely combinational ALU and branch comparator for the
//               execute stage. Results wrap modulo 2^C_XLEN; shift amounts
//               use the log2(C_XLEN) LSBs of the right operand.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_alu
  import ex_pipe_stage_pkg::*;
#(
  parameter int C_XLEN = C_XLEN_DEFAULT
) (
  input  t_alu_op           i_op,
  input  logic [C_XLEN-1:0] i_left,
  input  logic [C_XLEN-1:0] i_right,
  input  logic [C_XLEN-1:0] i_cmp_left,
  input  logic [C_XLEN-1:0] i_cmp_right,
  input  logic [2:0]        i_funct3,
  output logic [C_XLEN-1:0] o_result,
  output logic              o_cmp
);

  localparam int C_SHW = $clog2(C_XLEN);

  logic [C_SHW-1:0] w_shamt;
  logic             w_lt_s;
  logic             w_lt_u;
  logic             w_cmp_eq;
  logic             w_cmp_lt_s;
  logic             w_cmp_lt_u;

  assign w_shamt    = i_right[C_SHW-1:0];
  assign w_lt_s     = $signed(i_left) < $signed(i_right);
  assign w_lt_u     = i_left < i_right;
  assign w_cmp_eq   = i_cmp_left == i_cmp_right;
  assign w_cmp_lt_s = $signed(i_cmp_left) < $signed(i_cmp_right);
  assign w_cmp_lt_u = i_cmp_left < i_cmp_right;

  // ALU result selection
  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD:        o_result = i_left + i_right;
      ALU_SUB:        o_result = i_left - i_right;
      ALU_SLL:        o_result = i_left << w_shamt;
      ALU_SLT:        o_result = {{(C_XLEN-1){1'b0}}, w_lt_s};
      ALU_SLTU:       o_result = {{(C_XLEN-1){1'b0}}, w_lt_u};
      ALU_XOR:        o_result = i_left ^ i_right;
      ALU_SRL:        o_result = i_left >> w_shamt;
      ALU_SRA:        o_result = C_XLEN'($signed(i_left) >>> w_shamt);
      ALU_OR:         o_result = i_left | i_right;
      ALU_AND:        o_result = i_left & i_right;
      ALU_PASS_RIGHT: o_result = i_right;
      default:        o_result = '0;
    endcase
  end

  // Branch condition; reserved funct3 codes never take
  always_comb begin
    o_cmp = 1'b0;
    case (i_funct3)
      C_F3_BEQ:  o_cmp = w_cmp_eq;
      C_F3_BNE:  o_cmp = ~w_cmp_eq;
      C_F3_BLT:  o_cmp = w_cmp_lt_s;
      C_F3_BGE:  o_cmp = ~w_cmp_lt_s;
      C_F3_BLTU: o_cmp = w_cmp_lt_u;
      C_F3_BGEU: o_cmp = ~w_cmp_lt_u;
      default:   o_cmp = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ex_pipe_stage.sv
// ============================================================================
// Module      : ex_pipe_stage
// Description : Merlin RISC-V execute stage. Accepts decoded instructions
//               over a dav/ack handshake, evaluates ALU/branch/link, and
//               issues registered write-back, load/store-queue and redirect
//               outputs with one cycle of latency. Instructions accepted in
//               the shadow of a taken redirect are squashed.
//               Build option: RV_COMPRESSED_EN selects a +2 link increment
//               for 16-bit instructions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_pipe_stage
  import ex_pipe_stage_pkg::*;
#(
  parameter int C_XLEN          = C_XLEN_DEFAULT,
  parameter int C_BRANCH_SHADOW = 1
) (
  input  logic              clk_i,
  input  logic              clk_en_i,
  input  logic              resetb_i,
  // decoder interface
  input  logic              ids_dav_i,
  output logic              ids_ack_o,
  input  logic              ids_cond_i,
  input  logic              ids_jump_i,
  input  logic              ids_link_i,
  input  logic              ids_ins_size_i,
  input  t_zone             ids_zone_i,
  input  t_alu_op           ids_alu_op_i,
  input  logic [C_XLEN-1:0] ids_pc_i,
  input  logic [C_XLEN-1:0] ids_operand_left_i,
  input  logic [C_XLEN-1:0] ids_operand_right_i,
  input  logic [C_XLEN-1:0] ids_regs1_data_i,
  input  logic [C_XLEN-1:0] ids_regs2_data_i,
  input  logic [C_XLEN-1:0] ids_imm_i,
  input  logic [4:0]        ids_regd_addr_i,
  input  logic [2:0]        ids_funct3_i,
  // write-back
  output logic              ids_regd_wr_o,
  output logic [4:0]        ids_regd_addr_o,
  output logic [C_XLEN-1:0] ids_regd_data_o,
  // hart vectoring
  output logic              hvec_vec_strobe_o,
  output logic [C_XLEN-1:0] hvec_vec_o,
  output logic [C_XLEN-1:0] hvec_pc_o,
  // load/store queue
  input  logic              lsq_lq_full_i,
  input  logic              lsq_sq_full_i,
  output logic              lsq_lq_wr_o,
  output logic              lsq_sq_wr_o,
  output logic [2:0]        lsq_funct3_o,
  output logic [4:0]        lsq_regd_addr_o,
  output logic [C_XLEN-1:0] lsq_regs2_data_o,
  output logic [C_XLEN-1:0] lsq_addr_o
);

  localparam bit         C_SHADOW_EN   = (C_BRANCH_SHADOW > 0);
  localparam logic [2:0] C_SHADOW_LOAD = 3'(C_BRANCH_SHADOW);

  logic              w_stall;
  logic              w_ack;
  logic [C_XLEN-1:0] w_alu_result;
  logic              w_cmp;
  logic              w_taken;
  logic [C_XLEN-1:0] w_target;
  logic [C_XLEN-1:0] w_pc_inc;
  logic [C_XLEN-1:0] w_regd_data;

  t_ex_state         r_state;
  logic [2:0]        r_shadow_cnt;

  ex_alu #(
    .C_XLEN (C_XLEN)
  ) u_alu (
    .i_op        (ids_alu_op_i),
    .i_left      (ids_operand_left_i),
    .i_right     (ids_operand_right_i),
    .i_cmp_left  (ids_regs1_data_i),
    .i_cmp_right (ids_regs2_data_i),
    .i_funct3    (ids_funct3_i),
    .o_result    (w_alu_result),
    .o_cmp       (w_cmp)
  );

  // A full destination queue holds the instruction in the decoder
  assign w_stall = ((ids_zone_i == ZONE_LOADQ)  & lsq_lq_full_i) |
                   ((ids_zone_i == ZONE_STOREQ) & lsq_sq_full_i);

  assign w_ack     = clk_en_i & ids_dav_i & ~w_stall & resetb_i;
  assign ids_ack_o = w_ack;

  assign w_taken = ids_jump_i | (ids_cond_i & w_cmp);

  // Jumps (JAL/JALR) take the ALU sum with bit 0 cleared; branches are pc-relative
  assign w_target = ids_cond_i ? (ids_pc_i + ids_imm_i)
                               : {w_alu_result[C_XLEN-1:1], 1'b0};

`ifdef RV_COMPRESSED_EN
  assign w_pc_inc = ids_pc_i + (ids_ins_size_i ? C_XLEN'(2) : C_XLEN'(4));
`else
  // Only 32-bit instructions exist in this build; the size flag is unused
  logic w_unused_ins_size;
  assign w_unused_ins_size = ids_ins_size_i;
  assign w_pc_inc          = ids_pc_i + C_XLEN'(4);
`endif

  assign w_regd_data = ids_link_i ? w_pc_inc : w_alu_result;

  // Output registers, strobe generation and branch-shadow state machine
  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      r_state           <= ST_RUN;
      r_shadow_cnt      <= 3'd0;
      ids_regd_wr_o     <= 1'b0;
      ids_regd_addr_o   <= '0;
      ids_regd_data_o   <= '0;
      hvec_vec_strobe_o <= 1'b0;
      hvec_vec_o        <= '0;
      hvec_pc_o         <= '0;
      lsq_lq_wr_o       <= 1'b0;
      lsq_sq_wr_o       <= 1'b0;
      lsq_funct3_o      <= '0;
      lsq_regd_addr_o   <= '0;
      lsq_regs2_data_o  <= '0;
      lsq_addr_o        <= '0;
    end else if (clk_en_i) begin
      // Strobes are single-cycle unless a new accept re-asserts them
      ids_regd_wr_o     <= 1'b0;
      hvec_vec_strobe_o <= 1'b0;
      lsq_lq_wr_o       <= 1'b0;
      lsq_sq_wr_o       <= 1'b0;

      if (w_ack) begin
        ids_regd_addr_o  <= ids_regd_addr_i;
        ids_regd_data_o  <= w_regd_data;
        hvec_vec_o       <= w_target;
        hvec_pc_o        <= ids_pc_i;
        lsq_funct3_o     <= ids_funct3_i;
        lsq_regd_addr_o  <= ids_regd_addr_i;
        lsq_regs2_data_o <= ids_regs2_data_i;
        lsq_addr_o       <= w_alu_result;

        case (r_state)
          ST_RUN: begin
            ids_regd_wr_o     <= (ids_zone_i == ZONE_REGFILE) && (ids_regd_addr_i != 5'd0);
            lsq_lq_wr_o       <= (ids_zone_i == ZONE_LOADQ);
            lsq_sq_wr_o       <= (ids_zone_i == ZONE_STOREQ);
            hvec_vec_strobe_o <= w_taken;
            if (w_taken && C_SHADOW_EN) begin
              r_state      <= ST_SHADOW;
              r_shadow_cnt <= C_SHADOW_LOAD;
            end
          end
          ST_SHADOW: begin
            // Squashed: counts down, emits nothing, even if it would redirect
            if (r_shadow_cnt <= 3'd1) begin
              r_state      <= ST_RUN;
              r_shadow_cnt <= 3'd0;
            end else begin
              r_shadow_cnt <= r_shadow_cnt - 3'd1;
            end
          end
          default: begin
            r_state      <= ST_RUN;
            r_shadow_cnt <= 3'd0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_pipe_stage.sv
// ============================================================================
// Module      : tb_ex_pipe_stage
// Description : Self-checking bench for ex_pipe_stage (C_XLEN=32,
//               C_BRANCH_SHADOW=1). Table of directed vectors plus
//               hand-written reset/shadow/clock-enable sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_pipe_stage;
  import ex_pipe_stage_pkg::*;

`ifdef RV_COMPRESSED_EN
  localparam logic [31:0] C_LINK_EXP = 32'h42;
`else
  localparam logic [31:0] C_LINK_EXP = 32'h44;
`endif

  logic        clk_i = 1'b0;
  logic        clk_en_i;
  logic        resetb_i;
  logic        ids_dav_i, ids_ack_o, ids_cond_i, ids_jump_i, ids_link_i, ids_ins_size_i;
  t_zone       ids_zone_i;
  t_alu_op     ids_alu_op_i;
  logic [31:0] ids_pc_i, ids_operand_left_i, ids_operand_right_i;
  logic [31:0] ids_regs1_data_i, ids_regs2_data_i, ids_imm_i;
  logic [4:0]  ids_regd_addr_i;
  logic [2:0]  ids_funct3_i;
  logic        ids_regd_wr_o;
  logic [4:0]  ids_regd_addr_o;
  logic [31:0] ids_regd_data_o;
  logic        hvec_vec_strobe_o;
  logic [31:0] hvec_vec_o, hvec_pc_o;
  logic        lsq_lq_full_i, lsq_sq_full_i, lsq_lq_wr_o, lsq_sq_wr_o;
  logic [2:0]  lsq_funct3_o;
  logic [4:0]  lsq_regd_addr_o;
  logic [31:0] lsq_regs2_data_o, lsq_addr_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  ex_pipe_stage #(
    .C_XLEN          (32),
    .C_BRANCH_SHADOW (1)
  ) dut (
    .clk_i               (clk_i),
    .clk_en_i            (clk_en_i),
    .resetb_i            (resetb_i),
    .ids_dav_i           (ids_dav_i),
    .ids_ack_o           (ids_ack_o),
    .ids_cond_i          (ids_cond_i),
    .ids_jump_i          (ids_jump_i),
    .ids_link_i          (ids_link_i),
    .ids_ins_size_i      (ids_ins_size_i),
    .ids_zone_i          (ids_zone_i),
    .ids_alu_op_i        (ids_alu_op_i),
    .ids_pc_i            (ids_pc_i),
    .ids_operand_left_i  (ids_operand_left_i),
    .ids_operand_right_i (ids_operand_right_i),
    .ids_regs1_data_i    (ids_regs1_data_i),
    .ids_regs2_data_i    (ids_regs2_data_i),
    .ids_imm_i           (ids_imm_i),
    .ids_regd_addr_i     (ids_regd_addr_i),
    .ids_funct3_i        (ids_funct3_i),
    .ids_regd_wr_o       (ids_regd_wr_o),
    .ids_regd_addr_o     (ids_regd_addr_o),
    .ids_regd_data_o     (ids_regd_data_o),
    .hvec_vec_strobe_o   (hvec_vec_strobe_o),
    .hvec_vec_o          (hvec_vec_o),
    .hvec_pc_o           (hvec_pc_o),
    .lsq_lq_full_i       (lsq_lq_full_i),
    .lsq_sq_full_i       (lsq_sq_full_i),
    .lsq_lq_wr_o         (lsq_lq_wr_o),
    .lsq_sq_wr_o         (lsq_sq_wr_o),
    .lsq_funct3_o        (lsq_funct3_o),
    .lsq_regd_addr_o     (lsq_regd_addr_o),
    .lsq_regs2_data_o    (lsq_regs2_data_o),
    .lsq_addr_o          (lsq_addr_o)
  );

  typedef struct {
    logic [95:0] name;
    logic        dav, cond, jump, link, size, lqf, sqf;
    t_zone       zone;
    t_alu_op     op;
    logic [31:0] pc, left, right, rs1, rs2, imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        e_ack, e_wr, e_lq, e_sq, e_vs;
    logic        chk_data;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        chk_vec;
    logic [31:0] e_vec, e_hpc;
    logic        chk_lsq;
    logic [31:0] e_addr;
  } t_vec;

  t_vec tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic t_vec alu_v(input logic [95:0] nm, input t_zone z, input t_alu_op op,
                                 input logic [31:0] l, input logic [31:0] r, input logic [4:0] rd);
    t_vec v;
    v.name = nm; v.dav = 1'b1; v.cond = 1'b0; v.jump = 1'b0; v.link = 1'b0;
    v.size = 1'b0; v.lqf = 1'b0; v.sqf = 1'b0; v.zone = z; v.op = op;
    v.pc = 32'h0; v.left = l; v.right = r; v.rs1 = 32'h0; v.rs2 = 32'h0;
    v.imm = 32'h0; v.rd = rd; v.f3 = 3'b010;
    v.e_ack = 1'b0; v.e_wr = 1'b0; v.e_lq = 1'b0; v.e_sq = 1'b0; v.e_vs = 1'b0;
    v.chk_data = 1'b0; v.e_rd = rd; v.e_data = 32'h0;
    v.chk_vec = 1'b0; v.e_vec = 32'h0; v.e_hpc = 32'h0;
    v.chk_lsq = 1'b0; v.e_addr = 32'h0;
    return v;
  endfunction

  function automatic t_vec br_v(input logic [95:0] nm, input logic [2:0] f3,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] pc, input logic [31:0] imm);
    t_vec v;
    v = alu_v(nm, ZONE_NONE, ALU_ADD, 32'h0, 32'h0, 5'd0);
    v.cond = 1'b1; v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2; v.pc = pc; v.imm = imm;
    v.e_ack = 1'b1; v.e_hpc = pc;
    return v;
  endfunction

  task automatic drive(input t_vec v);
    ids_dav_i = v.dav; ids_cond_i = v.cond; ids_jump_i = v.jump; ids_link_i = v.link;
    ids_ins_size_i = v.size; ids_zone_i = v.zone; ids_alu_op_i = v.op;
    ids_pc_i = v.pc; ids_operand_left_i = v.left; ids_operand_right_i = v.right;
    ids_regs1_data_i = v.rs1; ids_regs2_data_i = v.rs2; ids_imm_i = v.imm;
    ids_regd_addr_i = v.rd; ids_funct3_i = v.f3;
    lsq_lq_full_i = v.lqf; lsq_sq_full_i = v.sqf;
  endtask

  // Simple ALU/REGFILE vector: accepted, written, data checked
  task automatic push_reg(input logic [95:0] nm, input t_alu_op op, input logic [31:0] l,
                          input logic [31:0] r, input logic [4:0] rd, input logic [31:0] exp);
    t_vec v;
    v = alu_v(nm, ZONE_REGFILE, op, l, r, rd);
    v.e_ack = 1'b1; v.e_wr = 1'b1; v.chk_data = 1'b1; v.e_data = exp;
    tbl.push_back(v);
  endtask

  initial begin
    t_vec v;

    // ---------------- vector table ----------------
    push_reg("add", ALU_ADD, 32'd5, 32'd7, 5'd3, 32'd12);
    v = alu_v("idle", ZONE_REGFILE, ALU_SUB, 32'd1, 32'd1, 5'd9);
    v.dav = 1'b0; v.chk_data = 1'b1; v.e_rd = 5'd3; v.e_data = 32'd12; tbl.push_back(v);
    v = alu_v("ld_full", ZONE_LOADQ, ALU_ADD, 32'h1000, 32'h10, 5'd4);
    v.lqf = 1'b1; tbl.push_back(v);
    v = alu_v("ld", ZONE_LOADQ, ALU_ADD, 32'h1000, 32'h10, 5'd4);
    v.e_ack = 1'b1; v.e_lq = 1'b1; v.chk_lsq = 1'b1; v.e_addr = 32'h1010; tbl.push_back(v);
    v = alu_v("ld_rd0", ZONE_LOADQ, ALU_ADD, 32'h1000, 32'h4, 5'd0);
    v.sqf = 1'b1; v.e_ack = 1'b1; v.e_lq = 1'b1; v.chk_lsq = 1'b1; v.e_addr = 32'h1004;
    tbl.push_back(v);
    v = alu_v("st", ZONE_STOREQ, ALU_ADD, 32'h2000, 32'h8, 5'd0);
    v.rs2 = 32'hDEAD_BEEF; v.f3 = 3'b001; v.lqf = 1'b1;
    v.e_ack = 1'b1; v.e_sq = 1'b1; v.chk_lsq = 1'b1; v.e_addr = 32'h2008; tbl.push_back(v);
    v = alu_v("st_full", ZONE_STOREQ, ALU_ADD, 32'h2000, 32'h8, 5'd0);
    v.sqf = 1'b1; tbl.push_back(v);
    push_reg("sub", ALU_SUB, 32'd3, 32'd5, 5'd5, 32'hFFFF_FFFE);
    push_reg("sra", ALU_SRA, 32'h8000_0000, 32'd33, 5'd6, 32'hC000_0000);
    push_reg("srl", ALU_SRL, 32'h8000_0000, 32'd4, 5'd6, 32'h0800_0000);
    push_reg("sll", ALU_SLL, 32'd1, 32'd35, 5'd6, 32'd8);
    push_reg("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd8, 32'd1);
    push_reg("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd8, 32'd0);
    push_reg("xor", ALU_XOR, 32'h0000_F0F0, 32'h0000_FF00, 5'd8, 32'h0000_0FF0);
    push_reg("or", ALU_OR, 32'h0000_F0F0, 32'h0000_0F01, 5'd8, 32'h0000_FFF1);
    push_reg("and", ALU_AND, 32'h0000_F0F0, 32'h0000_3C3C, 5'd8, 32'h0000_3030);
    push_reg("pass", ALU_PASS_RIGHT, 32'h1111, 32'h1234, 5'd8, 32'h1234);
    push_reg("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'd1);
    v = alu_v("rd0", ZONE_REGFILE, ALU_ADD, 32'd1, 32'd2, 5'd0);
    v.e_ack = 1'b1; tbl.push_back(v);
    v = br_v("beq", 3'b000, 32'd9, 32'd9, 32'h100, 32'h20);
    v.e_vs = 1'b1; v.chk_vec = 1'b1; v.e_vec = 32'h120; tbl.push_back(v);
    v = alu_v("shadow1", ZONE_REGFILE, ALU_ADD, 32'd1, 32'd1, 5'd7);
    v.e_ack = 1'b1; tbl.push_back(v);
    push_reg("post_shd", ALU_ADD, 32'd2, 32'd2, 5'd7, 32'd4);
    v = br_v("bne_nt", 3'b001, 32'd9, 32'd9, 32'h180, 32'h40); tbl.push_back(v);
    v = br_v("blt", 3'b100, 32'hFFFF_FFFF, 32'd2, 32'h200, 32'hFFFF_FFF0);
    v.e_vs = 1'b1; v.chk_vec = 1'b1; v.e_vec = 32'h1F0; tbl.push_back(v);
    v = br_v("beq_shd", 3'b000, 32'd1, 32'd1, 32'h210, 32'h40); tbl.push_back(v);
    v = alu_v("jalr", ZONE_REGFILE, ALU_ADD, 32'h203, 32'h0, 5'd1);
    v.jump = 1'b1; v.link = 1'b1; v.size = 1'b1; v.pc = 32'h40;
    v.e_ack = 1'b1; v.e_wr = 1'b1; v.e_vs = 1'b1; v.chk_vec = 1'b1;
    v.e_vec = 32'h202; v.e_hpc = 32'h40; v.chk_data = 1'b1; v.e_data = C_LINK_EXP;
    tbl.push_back(v);
    v = alu_v("jal_shd", ZONE_REGFILE, ALU_ADD, 32'd3, 32'd3, 5'd2);
    v.e_ack = 1'b1; tbl.push_back(v);
    v = br_v("bgeu_nt", 3'b111, 32'd1, 32'd2, 32'h280, 32'h8); tbl.push_back(v);
    v = br_v("f3_rsvd", 3'b010, 32'd1, 32'd1, 32'h290, 32'h8); tbl.push_back(v);
    v = br_v("bltu_nt", 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h2A0, 32'h8); tbl.push_back(v);
    v = br_v("bge", 3'b101, 32'd5, 32'hFFFF_FFFF, 32'h300, 32'h8);
    v.e_vs = 1'b1; v.chk_vec = 1'b1; v.e_vec = 32'h308; tbl.push_back(v);

    // ---------------- reset (clock enable low) ----------------
    clk_en_i = 1'b0; resetb_i = 1'b0;
    drive(alu_v("rst", ZONE_REGFILE, ALU_ADD, 32'd1, 32'd1, 5'd1));
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst.ack", ids_ack_o, 0);
    chk("rst.wr", ids_regd_wr_o, 0);
    chk("rst.vs", hvec_vec_strobe_o, 0);
    chk("rst.lq", lsq_lq_wr_o, 0);
    chk("rst.sq", lsq_sq_wr_o, 0);
    chk("rst.data", ids_regd_data_o, 0);
    chk("rst.vec", hvec_vec_o, 0);
    chk("rst.addr", lsq_addr_o, 0);
    @(negedge clk_i);
    resetb_i = 1'b1; clk_en_i = 1'b1;

    // ---------------- table run ----------------
    foreach (tbl[i]) begin
      @(negedge clk_i);
      drive(tbl[i]);
      #1;
      chk($sformatf("%0s.ack", tbl[i].name), ids_ack_o, tbl[i].e_ack);
      @(posedge clk_i);
      #1;
      chk($sformatf("%0s.wr", tbl[i].name), ids_regd_wr_o, tbl[i].e_wr);
      chk($sformatf("%0s.lq", tbl[i].name), lsq_lq_wr_o, tbl[i].e_lq);
      chk($sformatf("%0s.sq", tbl[i].name), lsq_sq_wr_o, tbl[i].e_sq);
      chk($sformatf("%0s.vs", tbl[i].name), hvec_vec_strobe_o, tbl[i].e_vs);
      if (tbl[i].chk_data) begin
        chk($sformatf("%0s.rd", tbl[i].name), ids_regd_addr_o, tbl[i].e_rd);
        chk($sformatf("%0s.data", tbl[i].name), ids_regd_data_o, tbl[i].e_data);
      end
      if (tbl[i].chk_vec) begin
        chk($sformatf("%0s.vec", tbl[i].name), hvec_vec_o, tbl[i].e_vec);
        chk($sformatf("%0s.hpc", tbl[i].name), hvec_pc_o, tbl[i].e_hpc);
      end
      if (tbl[i].chk_lsq) begin
        chk($sformatf("%0s.laddr", tbl[i].name), lsq_addr_o, tbl[i].e_addr);
        chk($sformatf("%0s.lrd", tbl[i].name), lsq_regd_addr_o, tbl[i].rd);
        chk($sformatf("%0s.lf3", tbl[i].name), lsq_funct3_o, tbl[i].f3);
        chk($sformatf("%0s.ldat", tbl[i].name), lsq_regs2_data_o, tbl[i].rs2);
      end
    end

    // ---------------- reset while in branch shadow ----------------
    @(negedge clk_i);
    resetb_i = 1'b0;
    drive(br_v("beq", 3'b000, 32'd1, 32'd1, 32'h500, 32'h10));
    #1;
    chk("shdrst.ack", ids_ack_o, 0);
    @(posedge clk_i);
    #1;
    chk("shdrst.vs", hvec_vec_strobe_o, 0);
    chk("shdrst.wr", ids_regd_wr_o, 0);
    chk("shdrst.vec", hvec_vec_o, 0);
    chk("shdrst.data", ids_regd_data_o, 0);
    @(negedge clk_i);
    resetb_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("postrst.vs", hvec_vec_strobe_o, 1);
    chk("postrst.vec", hvec_vec_o, 32'h510);
    chk("postrst.hpc", hvec_pc_o, 32'h500);
    // consume the shadow slot
    @(negedge clk_i);
    drive(alu_v("nop", ZONE_NONE, ALU_ADD, 32'd0, 32'd0, 5'd0));
    @(posedge clk_i);
    #1;
    chk("nop.vs", hvec_vec_strobe_o, 0);

    // ---------------- clock enable low freezes state ----------------
    @(negedge clk_i);
    drive(alu_v("add", ZONE_REGFILE, ALU_ADD, 32'd5, 32'd7, 5'd3));
    @(posedge clk_i);
    #1;
    chk("frz0.wr", ids_regd_wr_o, 1);
    chk("frz0.data", ids_regd_data_o, 32'd12);
    @(negedge clk_i);
    clk_en_i = 1'b0;
    drive(alu_v("sub", ZONE_REGFILE, ALU_SUB, 32'd1, 32'd1, 5'd9));
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("frz%0d.ack", k + 1), ids_ack_o, 0);
      @(posedge clk_i);
      #1;
      chk($sformatf("frz%0d.wr", k + 1), ids_regd_wr_o, 1);
      chk($sformatf("frz%0d.rd", k + 1), ids_regd_addr_o, 5'd3);
      chk($sformatf("frz%0d.data", k + 1), ids_regd_data_o, 32'd12);
      @(negedge clk_i);
    end
    clk_en_i = 1'b1;
    ids_dav_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("thaw.wr", ids_regd_wr_o, 0);
    chk("thaw.data", ids_regd_data_o, 32'd12);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_pipe_stage.md
Name: ex_pipe_stage

Overview:
Parametrised execute stage for the Merlin RISC-V core. It sits between the instruction decoder (ids) and write-back, the load/store queue (lsq) and the hart vectoring controller (hvec). It evaluates ALU ops, branch conditions and link values, and issues a one-cycle-latency registered result. It adds a real dav/ack handshake, per-queue back-pressure, branch-shadow squashing and generic XLEN.

Parameters:
C_XLEN, 32, datapath width; must be 32 or 64.
C_BRANCH_SHADOW, 1, number of accepted instructions squashed after a taken redirect (0..7; 0 disables squashing).

Ports:
clk_i  in  1  core clock
clk_en_i  in  1  global clock enable; low freezes all state and outputs
resetb_i  in  1  reset, synchronous, active-low
ids_dav_i  in  1  decoder has a valid instruction
ids_ack_o  out  1  instruction consumed this cycle (combinational)
ids_cond_i  in  1  conditional branch
ids_jump_i  in  1  unconditional jump (JAL/JALR)
ids_link_i  in  1  write pc-increment to regd instead of ALU result
ids_ins_size_i  in  1  1 = 16-bit instruction (used only with RV_COMPRESSED_EN)
ids_zone_i  in  t_zone  destination zone: NONE/REGFILE/LOADQ/STOREQ
ids_alu_op_i  in  t_alu_op  ALU operation
ids_pc_i  in  C_XLEN  instruction pc
ids_operand_left_i, ids_operand_right_i  in  C_XLEN  ALU operands
ids_regs1_data_i, ids_regs2_data_i  in  C_XLEN  rs1/rs2 data (comparator, store data)
ids_imm_i  in  C_XLEN  branch offset
ids_regd_addr_i  in  5  rd
ids_funct3_i  in  3  branch compare / memory size
ids_regd_wr_o  out  1  write-back strobe
ids_regd_addr_o  out  5  write-back rd
ids_regd_data_o  out  C_XLEN  write-back data
hvec_vec_strobe_o  out  1  redirect strobe
hvec_vec_o  out  C_XLEN  redirect target
hvec_pc_o  out  C_XLEN  pc of the redirecting instruction
lsq_lq_full_i, lsq_sq_full_i  in  1  load/store queue full
lsq_lq_wr_o, lsq_sq_wr_o  out  1  queue push strobes
lsq_funct3_o  out  3  access size/sign
lsq_regd_addr_o  out  5  load destination
lsq_regs2_data_o  out  C_XLEN  store data
lsq_addr_o  out  C_XLEN  effective address (ALU result)

Behaviour:
- Reset (resetb_i low at clk edge, regardless of clk_en_i): all strobes 0, all data/address outputs 0, shadow counter 0, state RUN.
- stall = (zone==LOADQ & lsq_lq_full_i) | (zone==STOREQ & lsq_sq_full_i).
- ids_ack_o = clk_en_i & ids_dav_i & ~stall & resetb_i.
- Accepted instruction: all outputs registered at the next edge (1-cycle latency).
- Cycle with clk_en_i high and no accept: all strobes cleared to 0; data outputs hold.
- clk_en_i low: everything holds, strobes included.
- Zone decode on accept:
  - REGFILE → ids_regd_wr_o=1, suppressed when rd==0.
  - LOADQ → lsq_lq_wr_o=1, issued even when rd==0.
  - STOREQ → lsq_sq_wr_o=1.
  - NONE → no strobe.
- regd data = pc_inc when ids_link_i, else ALU result.
- ALU ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_RIGHT.
  - Shift amount uses log2(C_XLEN) LSBs.
  - Results wrap modulo 2^C_XLEN.
- Comparator (funct3 on rs1/rs2): 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu; other encodings → not taken.
- taken = ids_jump_i | (ids_cond_i & cmp).
- Redirect target:
  - Conditional branch: pc + imm.
  - Jump: ALU result with bit 0 cleared.
- On a taken accept: hvec_vec_strobe_o=1 for one enabled cycle, with hvec_vec_o = target and hvec_pc_o = ids_pc_i.
- Shadow FSM (states RUN, SHADOW):
  - RUN → SHADOW on a taken accept when C_BRANCH_SHADOW>0; counter loads C_BRANCH_SHADOW.
  - In SHADOW, each accept decrements the counter and produces no strobes of any kind, a taken branch included. Stall rules still apply.
  - SHADOW → RUN when the counter reaches 0.
  - Reset mid-shadow returns to RUN.

Optional Feature:
RV_COMPRESSED_EN:
- Defined: pc_inc = pc + 2 when ids_ins_size_i=1, else pc + 4.
- Undefined: pc_inc = pc + 4 always; ids_ins_size_i is ignored. Redirect targets with bit 1 set are still issued unchanged; alignment faults are not this block's job.

Decomposition:
- Shared core package holds C_XLEN, t_zone (NONE, REGFILE, LOADQ, STOREQ), t_alu_op encodings, and branch funct3 constants.
- One sub-module, ex_alu: purely combinational ALU plus comparator, taking (op, left, right, cmp_left, cmp_right, funct3) and returning result and cmp.
- Handshake, zone decode, muxes and shadow FSM live in ex_pipe_stage.

Test Plan:
- ADD, REGFILE, left=5, right=7, rd=3 → next cycle ids_regd_wr_o=1, addr=3, data=12; following idle cycle wr=0.
- LOADQ with lsq_lq_full_i=1, dav=1 → ids_ack_o=0, no lq write. Full deasserts → ack=1, then lsq_lq_wr_o=1, lsq_addr_o=ALU sum.
- BEQ, rs1=rs2=9, pc=0x100, imm=0x20 → hvec_vec_strobe_o=1, vec=0x120, hvec_pc_o=0x100. Then next accepted REGFILE instruction (C_BRANCH_SHADOW=1) → no ids_regd_wr_o; the one after writes normally.
- JALR link, left=0x203, right=0, pc=0x40, rd=1 → vec=0x202, regd data=0x44. With RV_COMPRESSED_EN and ins_size=1 → data=0x42.
- REGFILE to rd=0 → ids_regd_wr_o stays 0. clk_en_i low for 3 cycles mid-stream → all outputs frozen.
- resetb_i low during SHADOW → all strobes 0; next taken branch redirects normally.
